// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit barrel shifter: ROR/ROL/LSR/ASR with one registered
// log-shift stage per amount bit and a valid/ready handshake on both sides.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [SHW-1:0]   in_amt_i,
    input  logic [1:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_zero_o
);

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    logic [SHW-1:0]            valid_q, valid_d;
    logic [SHW-1:0]            sign_q,  sign_d;
    logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0][1:0]       mode_q,  mode_d;
    logic [SHW-1:0][SHW-1:0]   amt_q,   amt_d;
    logic                      zero_q,  zero_d;
    logic                      stage_en;
    logic                      unused_ok;

    // ASR fill uses the sign captured at stage 0, never the intermediate MSB.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> sh) : {WIDTH{1'b0}};
        case (mode)
            MODE_ROR: shift_step = (d >> sh) | (d << (WIDTH - sh));
            MODE_ROL: shift_step = (d << sh) | (d >> (WIDTH - sh));
            MODE_LSR: shift_step = d >> sh;
            MODE_ASR: shift_step = (d >> sh) | fill;
            default:  shift_step = d;
        endcase
    endfunction

    assign stage_en    = !valid_q[SHW-1] || out_ready_i;
    assign in_ready_o  = stage_en;
    assign out_valid_o = valid_q[SHW-1];
    assign out_data_o  = data_q[SHW-1];
    assign out_zero_o  = zero_q;

    // Final-stage mode/amt/sign and already-consumed amount bits are carried but not read.
    assign unused_ok = ^{amt_q, mode_q[SHW-1], sign_q[SHW-1]};

    // Next-state for every stage: advance the whole pipe on stage_en, else hold.
    always_comb begin
        valid_d = valid_q;
        sign_d  = sign_q;
        data_d  = data_q;
        mode_d  = mode_q;
        amt_d   = amt_q;
        zero_d  = zero_q;
        if (stage_en) begin
            valid_d[0] = in_valid_i;
            sign_d[0]  = in_data_i[WIDTH-1];
            mode_d[0]  = in_mode_i;
            amt_d[0]   = in_amt_i;
            data_d[0]  = in_amt_i[0] ? shift_step(in_data_i, in_mode_i, in_data_i[WIDTH-1], 1)
                                     : in_data_i;
            for (int k = 1; k < SHW; k++) begin
                valid_d[k] = valid_q[k-1];
                sign_d[k]  = sign_q[k-1];
                mode_d[k]  = mode_q[k-1];
                amt_d[k]   = amt_q[k-1];
                data_d[k]  = amt_q[k-1][k] ? shift_step(data_q[k-1], mode_q[k-1], sign_q[k-1], 32'sd1 << k)
                                           : data_q[k-1];
            end
            zero_d = (data_d[SHW-1] == {WIDTH{1'b0}});
        end else begin
            zero_d = zero_q;
        end
    end

    // Stage registers with synchronous reset taking priority over the enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= {SHW{1'b0}};
            sign_q  <= {SHW{1'b0}};
            data_q  <= {(SHW*WIDTH){1'b0}};
            mode_q  <= {(SHW*2){1'b0}};
            amt_q   <= {(SHW*SHW){1'b0}};
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            amt_q   <= amt_d;
            zero_q  <= zero_d;
        end
    end

endmodule
